pr_read_sched: RTL and testbench

Read-burst scheduler for the PageRank accelerator's single AXI read master. It accepts line-granular read commands (base address, number of 64-byte lines) from two clients: client 0 is the rank-vector stream and client 1 is the edge-list stream. It splits each command into AXI AR bursts that are legal, capped and 4 KB-safe, and arbitrates between the two clients round-robin. It also limits outstanding bursts, routes R beats back by ID and reports per-client completion. It sits between the softreg-driven PageRank control logic and the shell's `*_m` AR/R channels.

---
 rtl/pr_pkg.sv | 27 ++
 rtl/pr_rr_arb2.sv | 20 ++
 rtl/pr_read_sched.sv | 146 ++++++++++++++
 tb/tb_pr_read_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pr_pkg.sv
// Shared constants, client IDs and state type for the PageRank read-burst scheduler.
package pr_pkg;
    localparam int         LINE_BYTES   = 64;
    localparam int         LINES_PER_4K = 64;
    localparam logic [2:0] AXI_SIZE_64B = 3'b110;

    localparam logic CL_RANK = 1'b0;
    localparam logic CL_EDGE = 1'b1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } cl_state_e;

    // Lines in the next burst: remaining work, burst cap and distance to the 4 KB page edge.
    function automatic logic [6:0] burst_lines(input logic [31:0] rem,
                                               input logic [31:0] cap,
                                               input logic [5:0]  line_in_page);
        logic [31:0] to_page;
        logic [31:0] n;
        to_page = 32'(LINES_PER_4K) - {26'd0, line_in_page};
        n = rem;
        if (cap < n) n = cap;
        if (to_page < n) n = to_page;
        return n[6:0];
    endfunction
endpackage

// File: rtl/pr_rr_arb2.sv
// Two-way round-robin arbiter; the last winner drops to lower priority on advance.
module pr_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    logic prio;

    always_comb begin
        grant = req;
        if (req == 2'b11) grant = prio ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prio <= 1'b0;
        else if (advance && (grant != 2'b00)) prio <= ~grant[1];
    end
endmodule

// File: rtl/pr_read_sched.sv
// Splits per-client line reads into capped, 4 KB-safe AXI AR bursts with
// round-robin arbitration, an outstanding-burst limit and R routing by ID.
module pr_read_sched
    import pr_pkg::*;
#(
    parameter int MAX_BURST = 8,
    parameter int MAX_OUTST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   cmd_valid,
    output logic [1:0]   cmd_ready,
    input  logic [63:0]  cmd_addr0,
    input  logic [63:0]  cmd_addr1,
    input  logic [31:0]  cmd_lines0,
    input  logic [31:0]  cmd_lines1,
    output logic [1:0]   done,
    output logic [1:0]   dvalid,
    input  logic [1:0]   dready,
    output logic         dlast,
    output logic [511:0] ddata,
    output logic [15:0]  arid_m,
    output logic [63:0]  araddr_m,
    output logic [7:0]   arlen_m,
    output logic [2:0]   arsize_m,
    output logic         arvalid_m,
    input  logic         arready_m,
    input  logic [15:0]  rid_m,
    input  logic [511:0] rdata_m,
    input  logic [1:0]   rresp_m,
    input  logic         rlast_m,
    input  logic         rvalid_m,
    output logic         rready_m
);
    // state     | meaning
    // ST_IDLE   | cmd_ready high, waiting for a command
    // ST_ACTIVE | issuing bursts and/or waiting for rlasts; done when both run out
    localparam int LINE_LSB = $clog2(LINE_BYTES);

    cl_state_e            state     [2];
    cl_state_e            st_nxt    [2];
    logic [63:LINE_LSB]   cur_line  [2];
    logic [63:LINE_LSB]   cmd_line  [2];
    logic [31:0]          cmd_cnt   [2];
    logic [31:0]          rem_lines [2];
    logic [3:0]           outst_c   [2];
    logic [6:0]           len       [2];
    logic [3:0]           outst_g;
    logic [3:0]           outst_g_upd;
    logic [1:0]           eligible, fin, c_inc, c_dec, req, grant;
    logic                 r_last, r_id, can_pick, issue, win;
    logic                 unused_bits;

    assign cmd_line[0] = cmd_addr0[63:LINE_LSB];
    assign cmd_line[1] = cmd_addr1[63:LINE_LSB];
    assign cmd_cnt[0]  = cmd_lines0;
    assign cmd_cnt[1]  = cmd_lines1;
    assign unused_bits = ^{rresp_m, cmd_addr0[LINE_LSB-1:0], cmd_addr1[LINE_LSB-1:0]};

    assign r_id     = rid_m[0];
    assign rready_m = dready[r_id];
    assign r_last   = rvalid_m & rready_m & rlast_m;
    assign dvalid   = {rvalid_m & (rid_m == {15'd0, CL_EDGE}),
                       rvalid_m & (rid_m == {15'd0, CL_RANK})};
    assign dlast    = rlast_m;
    assign ddata    = rdata_m;
    assign arsize_m = AXI_SIZE_64B;

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            len[c]      = burst_lines(rem_lines[c], 32'(MAX_BURST), cur_line[c][LINE_LSB+5:LINE_LSB]);
            eligible[c] = (state[c] == ST_ACTIVE) && (rem_lines[c] != 32'd0);
            fin[c]      = (state[c] == ST_ACTIVE) && (rem_lines[c] == 32'd0) && (outst_c[c] == 4'd0);
            c_inc[c]    = grant[c];
            c_dec[c]    = r_last && (int'(r_id) == c) && (outst_c[c] != 4'd0);
            st_nxt[c]   = state[c];
            case (state[c])
                ST_IDLE:   if (cmd_valid[c]) st_nxt[c] = ST_ACTIVE;
                ST_ACTIVE: if (fin[c]) st_nxt[c] = ST_IDLE;
                default:   st_nxt[c] = ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = {state[1] == ST_IDLE, state[0] == ST_IDLE};
    assign done      = fin;

    // Credit is judged on the count after this cycle's rlast, so a returning burst frees a slot at once.
    assign outst_g_upd = (r_last && (outst_g != 4'd0)) ? outst_g - 4'd1 : outst_g;
    assign can_pick    = (!arvalid_m || arready_m) && (outst_g_upd < 4'(MAX_OUTST));
    assign req         = can_pick ? eligible : 2'b00;
    assign issue       = |grant;
    assign win         = grant[1];

    pr_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (issue),
        .grant   (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                state[c]     <= ST_IDLE;
                cur_line[c]  <= '0;
                rem_lines[c] <= '0;
                outst_c[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                state[c] <= st_nxt[c];
                if ((state[c] == ST_IDLE) && cmd_valid[c]) begin
                    cur_line[c]  <= cmd_line[c];
                    rem_lines[c] <= cmd_cnt[c];
                end else if (grant[c]) begin
                    cur_line[c]  <= cur_line[c] + (64 - LINE_LSB)'(len[c]);
                    rem_lines[c] <= rem_lines[c] - 32'(len[c]);
                end
                if (c_inc[c] && !c_dec[c]) outst_c[c] <= outst_c[c] + 4'd1;
                else if (c_dec[c] && !c_inc[c]) outst_c[c] <= outst_c[c] - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outst_g   <= '0;
            arvalid_m <= 1'b0;
            araddr_m  <= '0;
            arid_m    <= '0;
            arlen_m   <= '0;
        end else begin
            outst_g <= outst_g_upd + {3'd0, issue};
            if (issue) begin
                arvalid_m <= 1'b1;
                araddr_m  <= {cur_line[win], {LINE_LSB{1'b0}}};
                arid_m    <= {15'd0, win};
                arlen_m   <= {1'b0, len[win]} - 8'd1;
            end else if (arready_m) begin
                arvalid_m <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pr_read_sched.sv
// Bench for pr_read_sched: AXI slave model, per-command burst lists derived from
// the splitting rules, and randomized traffic from both clients.
module tb_pr_read_sched;
    localparam int MAX_BURST = 8;
    localparam int MAX_OUTST = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   cmd_valid = '0;
    logic [1:0]   cmd_ready;
    logic [63:0]  cmd_addr0 = '0, cmd_addr1 = '0;
    logic [31:0]  cmd_lines0 = '0, cmd_lines1 = '0;
    logic [1:0]   done, dvalid;
    logic [1:0]   dready = '0;
    logic         dlast;
    logic [511:0] ddata;
    logic [15:0]  arid_m;
    logic [63:0]  araddr_m;
    logic [7:0]   arlen_m;
    logic [2:0]   arsize_m;
    logic         arvalid_m;
    logic         arready_m = 1'b0;
    logic [15:0]  rid_m = '0;
    logic [511:0] rdata_m = '0;
    logic [1:0]   rresp_m = '0;
    logic         rlast_m = 1'b0, rvalid_m = 1'b0;
    logic         rready_m;

    pr_read_sched #(.MAX_BURST(MAX_BURST), .MAX_OUTST(MAX_OUTST)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr0(cmd_addr0), .cmd_addr1(cmd_addr1),
        .cmd_lines0(cmd_lines0), .cmd_lines1(cmd_lines1),
        .done(done), .dvalid(dvalid), .dready(dready), .dlast(dlast), .ddata(ddata),
        .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
        .arvalid_m(arvalid_m), .arready_m(arready_m),
        .rid_m(rid_m), .rdata_m(rdata_m), .rresp_m(rresp_m), .rlast_m(rlast_m),
        .rvalid_m(rvalid_m), .rready_m(rready_m)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] addr; int lines; } cmd_t;
    typedef struct { logic [63:0] addr; int len; } burst_t;
    typedef struct { int id; int beats; int epoch; } rb_t;

    cmd_t   pend0[$], pend1[$];
    burst_t exp0[$], exp1[$];
    rb_t    sl_q[$];
    int     ar_id_log[$], ar_cyc_log[$], ar_len_log[$];
    logic [63:0] ar_addr_log[$];

    int n_chk = 0, n_pass = 0, cyc = 0, epoch = 0, outst_m = 0;
    int ar_prob = 100, rv_prob = 100, dr_prob = 100;
    bit r_stall = 1'b0;
    logic [1:0] busy = '0, done_due = '0;
    int ret_left[2], acc_cyc[2], done_cyc[2];
    logic hold_prev = 1'b0;
    logic [63:0] h_addr;
    logic [7:0]  h_len;
    logic [15:0] h_id;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic accept(input int c, input cmd_t cm);
        logic [63:0] a;
        int rem, n, to4k, blen;
        a = cm.addr & ~64'h3F;
        rem = cm.lines;
        n = 0;
        while (rem > 0) begin
            to4k = 64 - int'(a[11:6]);
            blen = rem;
            if (blen > MAX_BURST) blen = MAX_BURST;
            if (blen > to4k) blen = to4k;
            if (c == 0) exp0.push_back('{a, blen});
            else exp1.push_back('{a, blen});
            a = a + 64'(blen * 64);
            rem -= blen;
            n++;
        end
        ret_left[c] = n;
        busy[c] = 1'b1;
        acc_cyc[c] = cyc;
        if (n == 0) done_due[c] = 1'b1;
    endtask

    task automatic ar_accept();
        burst_t b;
        int id;
        bit ok;
        id = int'(arid_m);
        chk("arsize", 64'(arsize_m), 64'(3'b110));
        ok = (id == 0 && exp0.size() > 0) || (id == 1 && exp1.size() > 0);
        chk("ar_expected", 64'(ok), 64'(1));
        if (ok) begin
            if (id == 0) b = exp0.pop_front();
            else b = exp1.pop_front();
            chk("araddr", araddr_m, b.addr);
            chk("arlen", 64'(arlen_m), 64'(b.len - 1));
            sl_q.push_back('{id, b.len, epoch});
            outst_m++;
            chk("outst_cap", 64'(outst_m <= MAX_OUTST), 64'(1));
        end
        ar_id_log.push_back(id);
        ar_cyc_log.push_back(cyc);
        ar_addr_log.push_back(araddr_m);
        ar_len_log.push_back(int'(arlen_m));
    endtask

    task automatic drive();
        arready_m = ($urandom_range(99) < ar_prob);
        for (int c = 0; c < 2; c++) dready[c] = ($urandom_range(99) < dr_prob);
        if (sl_q.size() > 0 && !r_stall && ($urandom_range(99) < rv_prob)) begin
            rvalid_m = 1'b1;
            rid_m    = 16'(sl_q[0].id);
            rlast_m  = (sl_q[0].beats == 1);
        end else begin
            rvalid_m = 1'b0;
            rid_m    = 16'($urandom_range(1));
            rlast_m  = 1'($urandom_range(1));
        end
        for (int i = 0; i < 16; i++) rdata_m[i*32 +: 32] = $urandom;
        rresp_m = 2'($urandom_range(3));
        cmd_valid[0] = (pend0.size() > 0);
        cmd_valid[1] = (pend1.size() > 0);
        if (pend0.size() > 0) begin cmd_addr0 = pend0[0].addr; cmd_lines0 = 32'(pend0[0].lines); end
        if (pend1.size() > 0) begin cmd_addr1 = pend1[0].addr; cmd_lines1 = 32'(pend1[0].lines); end
    endtask

    task automatic sample();
        logic [1:0] exp_ready, acc, new_done;
        logic exp_rr;
        new_done = '0;
        exp_rr = dready[rid_m[0]];
        chk("rready_m", 64'(rready_m), 64'(exp_rr));
        chk("dvalid", 64'(dvalid), 64'({rvalid_m && (rid_m == 16'd1), rvalid_m && (rid_m == 16'd0)}));
        if (rvalid_m) begin
            chk("ddata", 64'(ddata == rdata_m), 64'(1));
            chk("dlast", 64'(dlast), 64'(rlast_m));
        end
        chk("done", 64'(done), 64'(done_due));
        exp_ready = ~busy;
        chk("cmd_ready", 64'(cmd_ready), 64'(exp_ready));
        for (int c = 0; c < 2; c++) if (done[c]) done_cyc[c] = cyc;
        if (hold_prev) begin
            chk("ar_hold_valid", 64'(arvalid_m), 64'(1));
            chk("ar_hold_addr", araddr_m, h_addr);
            chk("ar_hold_len", 64'(arlen_m), 64'(h_len));
            chk("ar_hold_id", 64'(arid_m), 64'(h_id));
        end
        if (arvalid_m && arready_m) ar_accept();
        hold_prev = arvalid_m && !arready_m;
        h_addr = araddr_m; h_len = arlen_m; h_id = arid_m;
        if (rvalid_m && exp_rr) begin
            sl_q[0].beats--;
            if (sl_q[0].beats == 0) begin
                if (outst_m > 0) outst_m--;
                if (sl_q[0].epoch == epoch) begin
                    ret_left[sl_q[0].id]--;
                    if (ret_left[sl_q[0].id] == 0) new_done[sl_q[0].id] = 1'b1;
                end
                void'(sl_q.pop_front());
            end
        end
        acc = cmd_valid & exp_ready;
        busy = busy & ~done_due;
        done_due = new_done;
        if (acc[0]) accept(0, pend0.pop_front());
        if (acc[1]) accept(1, pend1.pop_front());
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        #1 drive();
        #4 sample();
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_arvalid", 64'(arvalid_m), 64'(0));
        chk("rst_araddr", araddr_m, 64'(0));
        chk("rst_arid", 64'(arid_m), 64'(0));
        chk("rst_arlen", 64'(arlen_m), 64'(0));
        chk("rst_arsize", 64'(arsize_m), 64'(3'b110));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(2'b11));
        epoch++;
        exp0.delete(); exp1.delete(); pend0.delete(); pend1.delete();
        busy = '0; done_due = '0; outst_m = 0; hold_prev = 1'b0;
        cmd_valid = '0; arready_m = 1'b0; rvalid_m = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_idle(input string tag, input int budget);
        int k;
        bit idle;
        k = 0;
        idle = 1'b0;
        while (k < budget && !idle) begin
            idle = (pend0.size() + pend1.size() + exp0.size() + exp1.size() + sl_q.size() == 0)
                   && (busy == 2'b00) && (done_due == 2'b00);
            if (!idle) begin cycle(); k++; end
        end
        chk({"idle_", tag}, 64'(idle), 64'(1));
        cycle();
        cycle();
    endtask

    task automatic clear_log();
        ar_id_log.delete(); ar_cyc_log.delete(); ar_addr_log.delete(); ar_len_log.delete();
        done_cyc[0] = -1; done_cyc[1] = -1;
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t m;
        int sel;
        sel = $urandom_range(3);
        m.addr = {$urandom, $urandom};
        if (sel == 0) m.addr[11:6] = 6'($urandom_range(56, 63));
        if (sel == 1) m.addr[63:12] = '1;
        m.lines = $urandom_range(0, 40);
        return m;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // both clients, R stalled: alternating IDs and credit limit
        clear_log();
        r_stall = 1'b1;
        pend0.push_back('{64'h10000, 16});
        pend1.push_back('{64'h80000, 16});
        repeat (20) cycle();
        chk("t3_same_cycle", 64'(acc_cyc[1] - acc_cyc[0]), 64'(0));
        chk("t3_n_ar_stalled", 64'(ar_id_log.size()), 64'(4));
        if (ar_id_log.size() >= 4) begin
            chk("t3_id0", 64'(ar_id_log[0]), 64'(0));
            chk("t3_id1", 64'(ar_id_log[1]), 64'(1));
            chk("t3_id2", 64'(ar_id_log[2]), 64'(0));
            chk("t3_id3", 64'(ar_id_log[3]), 64'(1));
        end
        r_stall = 1'b0;
        run_idle("both", 400);

        // single read
        clear_log();
        pend0.push_back('{64'h1000, 20});
        run_idle("single", 300);
        chk("t1_n_ar", 64'(ar_id_log.size()), 64'(3));
        if (ar_id_log.size() == 3) begin
            chk("t1_addr0", ar_addr_log[0], 64'h1000);
            chk("t1_addr1", ar_addr_log[1], 64'h1200);
            chk("t1_addr2", ar_addr_log[2], 64'h1400);
            chk("t1_len0", 64'(ar_len_log[0]), 64'(7));
            chk("t1_len2", 64'(ar_len_log[2]), 64'(3));
            chk("t1_first_lat", 64'(ar_cyc_log[0] - acc_cyc[0]), 64'(2));
            chk("t1_b2b", 64'(ar_cyc_log[2] - ar_cyc_log[0]), 64'(2));
        end

        // 4 KB split
        clear_log();
        pend0.push_back('{64'h1FC0, 3});
        run_idle("split", 200);
        chk("t2_n_ar", 64'(ar_id_log.size()), 64'(2));
        if (ar_id_log.size() == 2) begin
            chk("t2_addr0", ar_addr_log[0], 64'h1FC0);
            chk("t2_len0", 64'(ar_len_log[0]), 64'(0));
            chk("t2_addr1", ar_addr_log[1], 64'h2000);
            chk("t2_len1", 64'(ar_len_log[1]), 64'(1));
        end

        // zero-line command
        clear_log();
        pend1.push_back('{64'h5000, 0});
        run_idle("zero", 50);
        chk("t4_n_ar", 64'(ar_id_log.size()), 64'(0));
        chk("t4_done_lat", 64'(done_cyc[1] - acc_cyc[1]), 64'(1));

        // AR backpressure
        clear_log();
        ar_prob = 0;
        pend0.push_back('{64'h3000, 24});
        repeat (8) cycle();
        chk("t5_stall_valid", 64'(arvalid_m), 64'(1));
        chk("t5_stall_addr", araddr_m, 64'h3000);
        chk("t5_stall_len", 64'(arlen_m), 64'(7));
        ar_prob = 100;
        run_idle("bp", 300);
        if (ar_cyc_log.size() >= 2)
            chk("t5_next_ar", 64'(ar_cyc_log[1] - ar_cyc_log[0]), 64'(1));
        else
            chk("t5_n_ar", 64'(ar_cyc_log.size()), 64'(3));

        // reset with two bursts outstanding
        clear_log();
        r_stall = 1'b1;
        pend0.push_back('{64'h7000, 32});
        for (int k = 0; k < 30 && ar_id_log.size() < 2; k++) cycle();
        ar_prob = 0;
        cycle();
        chk("t6_two_out", 64'(ar_id_log.size()), 64'(2));
        do_reset();
        ar_prob = 100;
        r_stall = 1'b0;
        run_idle("stale", 200);
        clear_log();
        pend0.push_back('{64'h9000, 5});
        run_idle("after_rst", 200);
        chk("t6_n_ar", 64'(ar_id_log.size()), 64'(1));
        if (ar_id_log.size() == 1) begin
            chk("t6_addr", ar_addr_log[0], 64'h9000);
            chk("t6_len", 64'(ar_len_log[0]), 64'(4));
        end

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            ar_prob = $urandom_range(30, 100);
            rv_prob = $urandom_range(30, 100);
            dr_prob = $urandom_range(30, 100);
            if (pend0.size() == 0 && $urandom_range(1) == 1) pend0.push_back(rand_cmd());
            if (pend1.size() == 0 && $urandom_range(1) == 1) pend1.push_back(rand_cmd());
            repeat ($urandom_range(5, 40)) cycle();
        end
        run_idle("rand", 5000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
